// File: rtl/fifo_pkg.sv
// Shared FIFO constants so the storage array, pointer controller and wrapper
// agree on geometry and threshold levels.
package fifo_pkg;

   localparam int unsigned W_ADDRESS = 4;
   localparam int unsigned W_DATA    = 8;
   localparam int unsigned L_FIFO    = 16;
   localparam int unsigned AF_LEVEL  = 14;
   localparam int unsigned AE_LEVEL  = 2;

   typedef logic [W_ADDRESS:0] fifo_ptr_t;

   function automatic int unsigned fifo_depth(input int unsigned w_addr);
      return 32'd1 << w_addr;
   endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// Wrap-around pointer counter with one extra wrap bit above the address bits.
module fifo_ptr_counter
   import fifo_pkg::*;
#(
   parameter int unsigned W = W_ADDRESS + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] STEP = {{(W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc)
         count <= count + STEP;
   end

endmodule

// File: rtl/fifo_pointer_ctrl.sv
// FIFO pointer/flag controller: gates push/pop requests, advances wrap-bit
// pointers, and derives full/empty, thresholds, occupancy and sticky errors.
module fifo_pointer_ctrl #(
   parameter int unsigned w_address = fifo_pkg::W_ADDRESS,
   parameter int unsigned L_fifo    = fifo_pkg::L_FIFO,
   parameter int unsigned AF_LEVEL  = fifo_pkg::AF_LEVEL,
   parameter int unsigned AE_LEVEL  = fifo_pkg::AE_LEVEL
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   output logic               wr_en_ptr,
   output logic [w_address:0] write_pointer,
   output logic [w_address:0] read_pointer,
   output logic               full,
   output logic               empty,
   output logic               almost_full,
   output logic               almost_empty,
   output logic [w_address:0] fifo_count,
   output logic               overflow,
   output logic               underflow
);

   localparam logic [w_address:0] CNT_ONE = {{w_address{1'b0}}, 1'b1};
   localparam logic [w_address:0] AF_CNT  = AF_LEVEL[w_address:0];
   localparam logic [w_address:0] AE_CNT  = AE_LEVEL[w_address:0];

   logic wr_accept;
   logic rd_accept;

   // Flags depend only on registered pointers, so request inputs cannot glitch them.
   always_comb begin
      empty = (write_pointer == read_pointer);
      full  = (write_pointer[w_address] != read_pointer[w_address]) &&
              (write_pointer[w_address-1:0] == read_pointer[w_address-1:0]);
   end

   always_comb begin
      wr_accept    = wr_en & ~full  & ~rst;
      rd_accept    = rd_en & ~empty & ~rst;
      wr_en_ptr    = wr_accept;
      almost_full  = (fifo_count >= AF_CNT);
      almost_empty = (fifo_count <= AE_CNT);
   end

   fifo_ptr_counter #(.W(w_address + 1)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .inc   (wr_accept),
      .count (write_pointer)
   );

   fifo_ptr_counter #(.W(w_address + 1)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .inc   (rd_accept),
      .count (read_pointer)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_count <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         case ({wr_accept, rd_accept})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
         if (wr_en && full)
            overflow <= 1'b1;
         if (rd_en && empty)
            underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_pointer_ctrl.sv
// Scoreboard bench for fifo_pointer_ctrl with a behavioural storage array.
module tb_fifo_pointer_ctrl;

   localparam int unsigned WA = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [7:0]    wdata = '0;
   logic          wr_en_ptr;
   logic [WA:0]   write_pointer;
   logic [WA:0]   read_pointer;
   logic          full, empty, almost_full, almost_empty;
   logic [WA:0]   fifo_count;
   logic          overflow, underflow;

   fifo_pointer_ctrl #(
      .w_address (WA),
      .L_fifo    (16),
      .AF_LEVEL  (14),
      .AE_LEVEL  (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (wr_en),
      .rd_en         (rd_en),
      .wr_en_ptr     (wr_en_ptr),
      .write_pointer (write_pointer),
      .read_pointer  (read_pointer),
      .full          (full),
      .empty         (empty),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .fifo_count    (fifo_count),
      .overflow      (overflow),
      .underflow     (underflow)
   );

   always #5 clk = ~clk;

   // Storage array model: written through the controller's strobe and pointer.
   logic [7:0] mem [16];
   always @(posedge clk)
      if (wr_en_ptr) mem[write_pointer[WA-1:0]] <= wdata;

   typedef struct {
      int  wr_en_ptr;
      int  wp;
      int  rp;
      int  full;
      int  empty;
      int  af;
      int  ae;
      int  cnt;
      int  ovf;
      int  unf;
      int  rd_chk;
      int  data;
   } exp_t;

   exp_t     sb[$];
   logic [7:0] ref_q[$];

   int checks = 0;
   int errors = 0;

   int m_cnt = 0, m_wp = 0, m_rp = 0, m_ovf = 0, m_unf = 0;
   logic [7:0] next_data = 8'h10;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // One clock cycle of stimulus; the expected outputs for this cycle go to the scoreboard.
   task automatic cycle(input bit r, input bit w, input bit rd);
      exp_t e;
      bit   m_full, m_empty, wacc, racc;
      @(posedge clk);
      #1;
      rst   = r;
      wr_en = w;
      rd_en = rd;
      wdata = next_data;
      m_full  = (m_cnt == 16);
      m_empty = (m_cnt == 0);
      wacc = w && !m_full && !r;
      racc = rd && !m_empty && !r;
      e.wr_en_ptr = wacc;
      e.wp = m_wp;  e.rp = m_rp;
      e.full = m_full;  e.empty = m_empty;
      e.af = (m_cnt >= 14);  e.ae = (m_cnt <= 2);
      e.cnt = m_cnt;  e.ovf = m_ovf;  e.unf = m_unf;
      e.rd_chk = racc;
      e.data = racc ? int'(ref_q[0]) : 0;
      sb.push_back(e);
      if (r) begin
         m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
         ref_q.delete();
      end else begin
         if (racc) void'(ref_q.pop_front());
         if (wacc) begin
            ref_q.push_back(next_data);
            next_data = next_data + 8'd1;
         end
         m_wp = (m_wp + int'(wacc)) % 32;
         m_rp = (m_rp + int'(racc)) % 32;
         m_cnt = m_cnt + int'(wacc) - int'(racc);
         if (w && m_full)  m_ovf = 1;
         if (rd && m_empty) m_unf = 1;
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("wr_en_ptr",     int'(wr_en_ptr),     e.wr_en_ptr);
         chk("write_pointer", int'(write_pointer), e.wp);
         chk("read_pointer",  int'(read_pointer),  e.rp);
         chk("full",          int'(full),          e.full);
         chk("empty",         int'(empty),         e.empty);
         chk("almost_full",   int'(almost_full),   e.af);
         chk("almost_empty",  int'(almost_empty),  e.ae);
         chk("fifo_count",    int'(fifo_count),    e.cnt);
         chk("overflow",      int'(overflow),      e.ovf);
         chk("underflow",     int'(underflow),     e.unf);
         if (e.rd_chk != 0)
            chk("pop_data", int'(mem[read_pointer[WA-1:0]]), e.data);
      end
   end

   initial begin
      // Bring DUT out of an unknown state before any expectation is recorded.
      @(posedge clk);
      #1;
      rst = 1'b1;
      cycle(1, 0, 0);
      repeat (2) cycle(0, 0, 0);
      repeat (16) cycle(0, 1, 0);
      cycle(0, 1, 0);
      repeat (20) cycle(0, 0, 0);
      repeat (16) cycle(0, 0, 1);
      cycle(0, 0, 1);
      repeat (2) cycle(0, 0, 0);
      repeat (8) cycle(0, 1, 0);
      repeat (40) cycle(0, 1, 1);
      repeat (3) cycle(0, 0, 1);
      cycle(1, 1, 1);
      repeat (2) cycle(0, 0, 0);
      cycle(0, 1, 1);
      repeat (15) cycle(0, 1, 0);
      cycle(0, 1, 1);
      repeat (2) cycle(0, 0, 0);
      cycle(0, 0, 0);
      for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
